// File: rtl/ungrouper_if.sv
// Memory-side bus of the ungrouper: start request, token/vocab read ports,
// output write port and run status.
interface ungrouper_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  cs;
    logic [DATA_WIDTH-1:0] val_token;
    logic [DATA_WIDTH-1:0] val_vocab;
    logic [ADDR_WIDTH-1:0] at;
    logic [ADDR_WIDTH-1:0] av;
    logic [ADDR_WIDTH-1:0] ao;
    logic [DATA_WIDTH-1:0] wd;
    logic                  w;
    logic                  done;
    logic                  err;

    // Environment side: owns the memories and the start request.
    modport master (
        output cs, val_token, val_vocab,
        input  at, av, ao, wd, w, done, err
    );

    // Expander side.
    modport slave (
        input  cs, val_token, val_vocab,
        output at, av, ao, wd, w, done, err
    );
endinterface

// File: rtl/ungrouper.sv
// Expands a zero-terminated token stream into the zero-separated vocab groups
// it names, writing the bytes (plus a final extra 0) to the output memory.
module ungrouper #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    ungrouper_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, SKIP, COPY, TERM, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] AMAX = '1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] at_q, av_q, ao_q, ao_d;
    logic [DATA_WIDTH-1:0] wd_q, cnt_q, k_q;
    logic                  w_q, done_q, err_q;
    logic                  ovf;

    // Output address advances after each committed write; it never wraps.
    always_comb begin
        ao_d = ao_q;
        if (w_q && (ao_q != AMAX))
            ao_d = ao_q + 1'b1;
    end

    // A write landing on the last output word while the stream still owes
    // more bytes (anything but the final terminator) aborts the run.
    assign ovf = w_q && (ao_q == AMAX) &&
                 (state_q inside {FETCH, SKIP, COPY});

    // Main sequencer: all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            at_q    <= '0;
            av_q    <= '0;
            ao_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            w_q  <= 1'b0;
            ao_q <= ao_d;
            if (ovf) begin
                err_q   <= 1'b1;
                done_q  <= 1'b1;
                state_q <= DONE;
            end else begin
                case (state_q)
                    IDLE: if (bus.cs) begin
                        at_q    <= '0;
                        ao_q    <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= FETCH;
                    end
                    FETCH: if (bus.val_token == '0) begin
                        w_q     <= 1'b1;
                        wd_q    <= '0;
                        state_q <= TERM;
                    end else begin
                        k_q     <= bus.val_token;
                        av_q    <= '0;
                        cnt_q   <= DATA_WIDTH'(1);
                        state_q <= SKIP;
                    end
                    // Walk the vocab counting separators until entry k starts.
                    SKIP: if (cnt_q == k_q) begin
                        state_q <= COPY;
                    end else if (av_q == AMAX) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (bus.val_vocab == '0)
                            cnt_q <= cnt_q + 1'b1;
                        av_q <= av_q + 1'b1;
                    end
                    COPY: if (bus.val_vocab != '0) begin
                        if (av_q == AMAX) begin
                            // Entry runs off the end of the vocab without a 0.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            w_q  <= 1'b1;
                            wd_q <= bus.val_vocab;
                            av_q <= av_q + 1'b1;
                        end
                    end else begin
                        w_q  <= 1'b1;
                        wd_q <= '0;
                        if (at_q == AMAX) begin
                            // Last token word consumed with no terminator.
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            at_q    <= at_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    TERM: begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: if (!bus.cs)
                        state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.at   = at_q;
    assign bus.av   = av_q;
    assign bus.ao   = ao_q;
    assign bus.wd   = wd_q;
    assign bus.w    = w_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_ungrouper.sv
// Directed bench for the ungrouper: models token/vocab/output memories and
// checks output bytes, write counts and status flags per scenario.
module tb_ungrouper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    logic [7:0] tok_mem [16];
    logic [7:0] voc_mem [16];
    logic [7:0] out_mem [16];
    logic [7:0] exp_mem [16];
    logic [7:0] e1      [8];
    int         wcnt = 0;
    int         checks = 0;
    int         errors = 0;

    ungrouper_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    ungrouper #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.val_token = tok_mem[bus.at];
    assign bus.val_vocab = voc_mem[bus.av];

    // Output memory: a write commits on the edge where w is high.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) out_mem[i] <= 8'hEE;
            wcnt <= 0;
        end else if (bus.w) begin
            out_mem[bus.ao] <= bus.wd;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic clear_out();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic load_tokens(input logic [7:0] t0, t1, t2, t3, t4);
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'h00;
        tok_mem[0] = t0; tok_mem[1] = t1; tok_mem[2] = t2;
        tok_mem[3] = t3; tok_mem[4] = t4;
    endtask

    task automatic start(input bit keep);
        @(negedge clk) bus.cs = 1'b0;
        @(negedge clk) bus.cs = 1'b1;
        @(negedge clk) if (!keep) bus.cs = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
        if (!bus.done) chk({tag, "_timeout"}, bus.done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_bytes(input string tag, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), out_mem[i], exp_mem[i]);
    endtask

    task automatic set_exp1();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hEE;
        for (int i = 0; i < 8; i++) exp_mem[i] = e1[i];
    endtask

    task automatic check_t1(input string tag);
        set_exp1();
        chk_bytes(tag, 9);
        chk({tag, "_wcnt"}, wcnt, 8);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        e1 = '{8'h64, 8'h65, 8'h66, 8'h00, 8'h61, 8'h62, 8'h00, 8'h00};
        voc_mem = '{8'h61, 8'h62, 8'h00, 8'h63, 8'h00, 8'h64, 8'h65, 8'h66,
                    8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        load_tokens(0, 0, 0, 0, 0);
        bus.cs = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_at", bus.at, 0);
        chk("rst_av", bus.av, 0);
        chk("rst_ao", bus.ao, 0);
        chk("rst_wd", bus.wd, 0);
        chk("rst_w", bus.w, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;

        // 1: tokens 3,1,0
        load_tokens(3, 1, 0, 0, 0);
        clear_out();
        start(0);
        wait_done("t1");
        check_t1("t1");

        // 2: empty stream
        load_tokens(0, 0, 0, 0, 0);
        clear_out();
        start(0);
        wait_done("t2");
        chk("t2_wcnt", wcnt, 1);
        chk("t2_b0", out_mem[0], 8'h00);
        chk("t2_b1", out_mem[1], 8'hEE);
        chk("t2_done", bus.done, 1);
        chk("t2_err", bus.err, 0);
        chk("t2_at", bus.at, 0);

        // 3: token past the vocab end
        load_tokens(5, 0, 0, 0, 0);
        clear_out();
        start(0);
        wait_done("t3");
        chk("t3_wcnt", wcnt, 0);
        chk("t3_err", bus.err, 1);
        chk("t3_done", bus.done, 1);
        chk("t3_av", bus.av, 15);

        // 4: output overflow after 16 bytes
        load_tokens(3, 3, 3, 3, 0);
        clear_out();
        start(0);
        wait_done("t4");
        for (int i = 0; i < 16; i++) exp_mem[i] = e1[i % 4];
        chk_bytes("t4", 16);
        chk("t4_wcnt", wcnt, 16);
        chk("t4_err", bus.err, 1);
        chk("t4_done", bus.done, 1);
        repeat (5) @(negedge clk);
        chk("t4_nomore", wcnt, 16);

        // 5: reset in the middle of copying token 3
        load_tokens(3, 1, 0, 0, 0);
        clear_out();
        start(0);
        for (int i = 0; i < 50 && !bus.w; i++) @(negedge clk);
        chk("t5_inCopy", bus.w, 1);
        rst = 1'b1;
        #1;
        chk("t5_w", bus.w, 0);
        chk("t5_ao", bus.ao, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_err", bus.err, 0);
        @(negedge clk) rst = 1'b0;
        clear_out();
        start(0);
        wait_done("t5r");
        check_t1("t5r");

        // 6: cs held high after completion does not restart
        clear_out();
        start(1);
        wait_done("t6a");
        check_t1("t6a");
        clear_out();
        repeat (10) @(negedge clk);
        chk("t6_hold_wcnt", wcnt, 0);
        chk("t6_hold_done", bus.done, 1);
        bus.cs = 1'b0;
        clear_out();
        start(0);
        wait_done("t6b");
        check_t1("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
